// File: rtl/dphy_rx_hs_lane_ctrl_if.sv
// Lane-side signal bundle for one D-PHY HS receive lane controller.
//   slave  : the lane controller. It takes the LP state, the enable and the raw
//            deserializer bytes. It drives the termination and deserializer
//            enables plus the aligned PPI byte stream and status pulses.
//   master : the environment. It drives the inputs and observes the outputs.
interface dphy_rx_hs_lane_ctrl_if;
  logic       enable_i;
  logic [1:0] lp_i;
  logic [7:0] byte_i;
  logic       byte_valid_i;
  logic       term_en_o;
  logic       hs_rx_en_o;
  logic [7:0] data_o;
  logic       valid_o;
  logic       active_o;
  logic       sync_o;
  logic       err_sot_o;

  modport slave (
    input  enable_i, lp_i, byte_i, byte_valid_i,
    output term_en_o, hs_rx_en_o, data_o, valid_o, active_o, sync_o, err_sot_o
  );

  modport master (
    output enable_i, lp_i, byte_i, byte_valid_i,
    input  term_en_o, hs_rx_en_o, data_o, valid_o, active_o, sync_o, err_sot_o
  );
endinterface

// File: rtl/dphy_rx_hs_lane_ctrl.sv
// Per-lane D-PHY high-speed receive controller.
// The block detects the SoT entry sequence on the LP lines (11 -> 01 -> 00).
// It then turns on HS termination and waits SETTLE_CYCLES. After that it
// enables the deserializer and searches the raw byte stream for SYNC_CODE at
// any bit offset. Once the code is found, it delivers bit-aligned payload
// bytes until the lane returns to stop state (LP-11).
// Ports:
//   clk_i, reset_i : byte clock and synchronous active-high reset
//   lane (slave)   : enable_i, lp_i, byte_i, byte_valid_i in;
//                    term_en_o, hs_rx_en_o, data_o, valid_o, active_o,
//                    sync_o, err_sot_o out. All outputs are registered.
module dphy_rx_hs_lane_ctrl #(
  parameter int         SETTLE_CYCLES = 8,
  parameter int         SYNC_TIMEOUT  = 32,
  parameter logic [7:0] SYNC_CODE     = 8'hB8
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  dphy_rx_hs_lane_ctrl_if.slave       lane
);

  localparam int CNT_MAX = (SETTLE_CYCLES > SYNC_TIMEOUT) ? SETTLE_CYCLES : SYNC_TIMEOUT;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] SETTLE_LAST  = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(SYNC_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    LP_RQST     = 3'd1,
    SETTLE      = 3'd2,
    SYNC_SEARCH = 3'd3,
    HS_ACTIVE   = 3'd4,
    ERR_WAIT    = 3'd5
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;         // settle clocks, then searched bytes
  logic [7:0]    prev_q, prev_d;       // previous valid raw byte
  logic [2:0]    off_q, off_d;         // latched sync bit offset
  logic [1:0]    lp_prev_q, lp_prev_d; // previous LP sample for 11->01 edge
  logic          term_en_q, term_en_d;
  logic          hs_rx_en_q, hs_rx_en_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          active_q, active_d;
  logic          sync_q, sync_d;
  logic          err_q, err_d;

  logic [15:0]   win;
  logic          match;
  logic [2:0]    match_off;
  logic [7:0]    aligned;
  logic          lp_stop;

  assign lp_stop = (lane.lp_i == 2'b11);
  assign win     = {lane.byte_i, prev_q};
  assign aligned = 8'(win >> off_q);

  // Scan from the highest offset downwards so the lowest matching offset is
  // written last and therefore wins.
  always_comb begin
    match     = 1'b0;
    match_off = 3'd0;
    for (int k = 7; k >= 0; k--) begin
      if (win[k +: 8] == SYNC_CODE) begin
        match     = 1'b1;
        match_off = 3'(k);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    prev_d    = prev_q;
    off_d     = off_q;
    lp_prev_d = lane.lp_i;
    data_d    = data_q;
    valid_d   = 1'b0;
    sync_d    = 1'b0;
    err_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (lane.lp_i == 2'b01 && lp_prev_q == 2'b11) state_d = LP_RQST;
      end
      LP_RQST: begin
        if (lane.lp_i == 2'b00) begin
          state_d = SETTLE;
          cnt_d   = '0;
        end else if (lane.lp_i != 2'b01) begin
          state_d = IDLE;
        end
      end
      SETTLE: begin
        if (lp_stop) begin
          state_d = IDLE;
        end else if (cnt_q == SETTLE_LAST) begin
          state_d = SYNC_SEARCH;
          cnt_d   = '0;
          prev_d  = 8'h00;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      SYNC_SEARCH: begin
        if (lp_stop) begin
          state_d = IDLE;
        end else if (lane.byte_valid_i) begin
          prev_d = lane.byte_i;
          // A match takes priority over a timeout on the same byte.
          if (match) begin
            off_d   = match_off;
            sync_d  = 1'b1;
            state_d = HS_ACTIVE;
          end else if (cnt_q == TIMEOUT_LAST) begin
            err_d   = 1'b1;
            state_d = ERR_WAIT;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      HS_ACTIVE: begin
        // Stop state wins over a byte that arrives in the same cycle.
        if (lp_stop) begin
          state_d = IDLE;
        end else if (lane.byte_valid_i) begin
          prev_d  = lane.byte_i;
          valid_d = 1'b1;
          data_d  = aligned;
        end
      end
      ERR_WAIT: begin
        if (lp_stop) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (!lane.enable_i) begin
      state_d = IDLE;
      valid_d = 1'b0;
      sync_d  = 1'b0;
      err_d   = 1'b0;
      data_d  = 8'h00;
    end

    // The level outputs follow the next state, so they change together with it.
    term_en_d  = (state_d == SETTLE) || (state_d == SYNC_SEARCH) || (state_d == HS_ACTIVE);
    hs_rx_en_d = (state_d == SYNC_SEARCH) || (state_d == HS_ACTIVE);
    active_d   = (state_d == HS_ACTIVE);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      prev_q     <= 8'h00;
      off_q      <= 3'd0;
      lp_prev_q  <= 2'b00;
      term_en_q  <= 1'b0;
      hs_rx_en_q <= 1'b0;
      data_q     <= 8'h00;
      valid_q    <= 1'b0;
      active_q   <= 1'b0;
      sync_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      prev_q     <= prev_d;
      off_q      <= off_d;
      lp_prev_q  <= lp_prev_d;
      term_en_q  <= term_en_d;
      hs_rx_en_q <= hs_rx_en_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      active_q   <= active_d;
      sync_q     <= sync_d;
      err_q      <= err_d;
    end
  end

  assign lane.term_en_o  = term_en_q;
  assign lane.hs_rx_en_o = hs_rx_en_q;
  assign lane.data_o     = data_q;
  assign lane.valid_o    = valid_q;
  assign lane.active_o   = active_q;
  assign lane.sync_o     = sync_q;
  assign lane.err_sot_o  = err_q;

endmodule

// File: tb/tb_dphy_rx_hs_lane_ctrl.sv
// Directed bench for dphy_rx_hs_lane_ctrl with hand-computed expectations.
// Inputs are driven after a #1 delay past the rising edge. Outputs are checked
// #1 after the rising edge that samples the stimulus.
module tb_dphy_rx_hs_lane_ctrl;
  logic clk_i = 1'b0;
  logic reset_i;
  int   n_cmp = 0;
  int   n_err = 0;

  dphy_rx_hs_lane_ctrl_if lane ();

  dphy_rx_hs_lane_ctrl dut (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .lane    (lane.slave)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // {term_en, hs_rx_en, active, sync, err_sot, valid}
  function automatic logic [15:0] flags();
    return {10'd0, lane.term_en_o, lane.hs_rx_en_o, lane.active_o,
            lane.sync_o, lane.err_sot_o, lane.valid_o};
  endfunction

  task automatic lp(input logic [1:0] v);
    lane.lp_i = v;
    step();
  endtask

  task automatic feed(input logic [7:0] b);
    lane.byte_valid_i = 1'b1;
    lane.byte_i       = b;
    step();
    lane.byte_valid_i = 1'b0;
  endtask

  // Call this with the lane already at LP-11 for at least one sampled cycle.
  // It ends with the controller in SYNC_SEARCH.
  task automatic sot();
    lp(2'b01);
    lp(2'b00);
    for (int i = 0; i < 8; i++) step();
  endtask

  initial begin
    reset_i           = 1'b1;
    lane.enable_i     = 1'b0;
    lane.lp_i         = 2'b11;
    lane.byte_i       = 8'h00;
    lane.byte_valid_i = 1'b0;
    step();
    step();
    chk("reset_flags", flags(), 16'h0000);
    chk("reset_data", {8'h00, lane.data_o}, 16'h0000);
    reset_i       = 1'b0;
    lane.enable_i = 1'b1;

    // Offset 0: the sync byte is seen at k=0 when the byte after it arrives.
    lp(2'b11);
    lp(2'b01);
    chk("lprqst_term_off", flags(), 16'h0000);
    lp(2'b00);
    chk("settle_term_on", flags(), 16'h0020);
    for (int i = 0; i < 7; i++) step();
    chk("settle_last_hs_off", flags(), 16'h0020);
    step();
    chk("search_hs_on", flags(), 16'h0030);
    feed(8'h00);
    feed(8'hB8);
    chk("off0_no_sync_yet", flags(), 16'h0030);
    feed(8'h11);
    chk("off0_sync", flags(), 16'h003C);
    feed(8'h22);
    chk("off0_d0_flags", flags(), 16'h0039);
    chk("off0_d0", {8'h00, lane.data_o}, 16'h0011);
    step();
    chk("off0_gap", flags(), 16'h0038);
    feed(8'h33);
    chk("off0_d1", {7'd0, lane.valid_o, lane.data_o}, 16'h0122);
    // Stop state while a byte arrives: the byte is dropped.
    lane.byte_valid_i = 1'b1;
    lane.byte_i       = 8'h44;
    lp(2'b11);
    lane.byte_valid_i = 1'b0;
    chk("stop_drop", flags(), 16'h0000);

    // Offset 3: C0,2D -> sync at k=3, then 05 yields A5.
    sot();
    feed(8'hC0);
    feed(8'h2D);
    chk("off3_sync", flags(), 16'h003C);
    feed(8'h05);
    chk("off3_data", {7'd0, lane.valid_o, lane.data_o}, 16'h01A5);
    lp(2'b11);

    // Timeout: 32 non-matching bytes.
    sot();
    for (int i = 0; i < 31; i++) feed(8'h00);
    chk("tmo_31_no_err", flags(), 16'h0030);
    feed(8'h00);
    chk("tmo_err", flags(), 16'h0002);
    lp(2'b00);
    chk("tmo_err_pulse", flags(), 16'h0000);
    lp(2'b00);
    chk("errwait_hold", flags(), 16'h0000);
    lp(2'b11);
    sot();
    feed(8'hB8);
    feed(8'h5A);
    chk("after_err_sync", flags(), 16'h003C);
    feed(8'h77);
    chk("after_err_data", {7'd0, lane.valid_o, lane.data_o}, 16'h015A);
    lp(2'b11);

    // Match on the 32nd byte wins over timeout: 0x17 after 00 gives k=5.
    sot();
    for (int i = 0; i < 31; i++) feed(8'h00);
    feed(8'h17);
    chk("match_beats_tmo", flags(), 16'h003C);
    feed(8'h0D);
    chk("off5_data", {7'd0, lane.valid_o, lane.data_o}, 16'h0168);
    lp(2'b11);

    // Abort in SETTLE.
    lp(2'b01);
    lp(2'b00);
    step();
    step();
    lp(2'b11);
    chk("abort_term_off", flags(), 16'h0000);
    for (int i = 0; i < 10; i++) step();
    chk("abort_stays_idle", flags(), 16'h0000);
    // Rejection in LP_RQST.
    lp(2'b01);
    lp(2'b10);
    chk("reject_term", flags(), 16'h0000);
    lp(2'b00);
    chk("reject_no_settle", flags(), 16'h0000);
    lp(2'b11);

    // Disable mid-packet.
    sot();
    feed(8'hB8);
    feed(8'h11);
    feed(8'h22);
    chk("pre_dis_data", {7'd0, lane.valid_o, lane.data_o}, 16'h0111);
    lane.enable_i = 1'b0;
    feed(8'h33);
    chk("dis_flags", flags(), 16'h0000);
    chk("dis_data", {8'h00, lane.data_o}, 16'h0000);
    lane.enable_i = 1'b1;
    lp(2'b11);
    sot();
    feed(8'hB8);
    feed(8'h11);
    chk("reen_sync", flags(), 16'h003C);
    feed(8'h22);
    chk("reen_data", {7'd0, lane.valid_o, lane.data_o}, 16'h0111);

    // Reset mid-packet.
    reset_i = 1'b1;
    feed(8'h33);
    chk("rst_flags", flags(), 16'h0000);
    chk("rst_data", {8'h00, lane.data_o}, 16'h0000);
    reset_i = 1'b0;
    lp(2'b11);
    sot();
    feed(8'hC0);
    feed(8'h2D);
    chk("post_rst_sync", flags(), 16'h003C);
    feed(8'h05);
    chk("post_rst_data", {7'd0, lane.valid_o, lane.data_o}, 16'h01A5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/dphy_rx_hs_lane_ctrl.md
# dphy_rx_hs_lane_ctrl

Per-lane high-speed receive controller for the D-PHY receiver. It watches the lane's low-power line state to detect the Start-of-Transmission (SoT) entry sequence, then enables HS termination and, after a settle time, the deserializer. It searches the raw deserialized bytes for the HS sync code at any bit offset and delivers bit-aligned payload bytes to the PPI until the lane returns to stop state. One instance sits per data lane, between the lane deserializer output and the lane-merging logic.

## Interface
- SETTLE_CYCLES, 8, clock cycles spent in SETTLE with termination on before sync search starts (≥1)
- SYNC_TIMEOUT, 32, valid bytes searched without a match before SoT error (≥2)
- SYNC_CODE, 8'hB8, HS sync byte (bit-serial order, bit 0 first)
- clk_i  in  1  byte clock; one clock, all logic on rising edge
- reset_i  in  1  synchronous, active-high reset
- enable_i  in  1  lane enabled by configuration; low forces IDLE
- lp_i  in  2  synchronized LP line state {Dp,Dn}
- byte_i  in  8  raw unaligned byte from deserializer, bit 0 earliest
- byte_valid_i  in  1  byte_i valid this cycle
- term_en_o  out  1  HS termination enable
- hs_rx_en_o  out  1  deserializer enable
- data_o  out  8  aligned payload byte
- valid_o  out  1  data_o valid
- active_o  out  1  RxActiveHS
- sync_o  out  1  RxSyncHS, one-cycle pulse
- err_sot_o  out  1  sync-not-found pulse

## Operation
- States: IDLE, LP_RQST, SETTLE, SYNC_SEARCH, HS_ACTIVE, ERR_WAIT.
- IDLE: lp_i==01 while previous sample was 11 -> LP_RQST.
- LP_RQST: lp_i==00 -> SETTLE; lp_i==01 -> stay; any other -> IDLE.
- SETTLE: term_en_o=1; counter counts clocks; after SETTLE_CYCLES cycles -> SYNC_SEARCH; lp_i==11 at any point -> IDLE (abort, no error).
- SYNC_SEARCH: term_en_o=1, hs_rx_en_o=1; prev byte register cleared to 0 on entry; on each byte_valid_i form 16-bit window W={byte_i, prev}, test W[k+7:k]==SYNC_CODE for k=0..7, lowest k wins; exact match only. Match -> latch off=k, -> HS_ACTIVE. Valid-byte counter reaching SYNC_TIMEOUT without match -> err_sot_o pulse, -> ERR_WAIT. lp_i==11 -> IDLE. prev updated with byte_i on every valid byte.
- HS_ACTIVE: each valid byte outputs W[off+7:off] (sync byte itself never output). Trailer bytes passed through unstripped. lp_i==11 -> IDLE.
- ERR_WAIT: term_en_o=0, hs_rx_en_o=0; lp_i==11 -> IDLE.
- enable_i==0: next state IDLE from any state; all outputs cleared next cycle.
- Simultaneous lp_i==11 and byte_valid_i in HS_ACTIVE: that byte is dropped; exit has priority. Simultaneous match and timeout count: match wins.

## Timing
- Reset: state IDLE, all outputs 0, data_o=8'h00, counters and prev cleared.
- All outputs registered. term_en_o rises the cycle after lp_i==00 is sampled in LP_RQST; falls the cycle after exit condition.
- sync_o and active_o rise one cycle after the matching byte_valid_i; active_o stays high until the cycle after lp_i==11 or enable_i low.
- valid_o/data_o: one-cycle latency from byte_valid_i; no bubbles inserted; valid_o follows byte_valid_i gaps.
- err_sot_o: one cycle, the cycle after the SYNC_TIMEOUT-th non-matching valid byte.
- Reset mid-operation: outputs 0 the cycle after reset_i is sampled high.

## Test plan
- Offset 0: lp 11,01,00; 8 settle cycles; bytes 00,B8,11,22 -> sync_o pulse one cycle after B8 byte, data_o 11 then 22, each valid_o one cycle after input.
- Offset 3: after settle feed C0,2D,05 -> match at 2D with off=3, next valid_o carries A5.
- Timeout: 32 bytes of 00 in SYNC_SEARCH -> err_sot_o single pulse after 32nd byte, term_en_o/hs_rx_en_o low; stays in ERR_WAIT until lp_i=11, then new SoT succeeds.
- Abort and rejection: lp_i 11 during SETTLE -> term_en_o drops next cycle, no sync_o; lp_i 10 in LP_RQST -> IDLE, term_en_o never rises.
- Stop: lp_i 11 in HS_ACTIVE concurrent with a valid byte -> byte dropped, active_o/valid_o low next cycle.
- enable_i low and reset_i high mid-packet -> all outputs 0 next cycle; re-enable then normal SoT -> correct sync and data.
